// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, default timing and frame lengths.
// Used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } uart_state_t;

   localparam int CLKS_PER_BIT_DEF = 434;
   localparam int DATA_BITS        = 8;
   localparam int FRAME_BITS       = 10;
   localparam int FRAME_BITS_PAR   = 11;
   localparam int CNT_W            = 16;

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick marks the last cycle of each UART bit.
// clear holds the count at zero so every frame starts on a fresh period.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk_50Mhz,
   input  logic rst_n,
   input  logic clear,
   output logic bit_tick
);

   logic [CNT_W-1:0] cnt;

   assign bit_tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk_50Mhz or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || bit_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/btn_uart_tx.sv
// Button-triggered UART transmitter with a one-entry pending byte buffer.
// Line outputs are registered one cycle behind the FSM state.
module btn_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int PARITY_EN    = 0
) (
   input  logic       clk_50Mhz,
   input  logic       rst_n,
   input  logic       send_tick,
   input  logic [7:0] din,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done_tick,
   output logic       overrun_tick
);

   uart_state_t state;
   uart_state_t state_nx;

   logic       bit_tick;
   logic [7:0] sh;
   logic       par;
   logic [2:0] idx;
   logic       pend_v;
   logic [7:0] pend_b;

   logic       stop_end;
   logic       take;
   logic       load;
   logic       load_pend;
   logic       store;
   logic       drop;
   logic [7:0] load_byte;
   logic       line_bit;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk_50Mhz(clk_50Mhz),
      .rst_n    (rst_n),
      .clear    (state == S_IDLE),
      .bit_tick (bit_tick)
   );

   // A new frame may begin from IDLE or straight out of the stop bit.
   always_comb begin
      stop_end  = (state == S_STOP) && bit_tick;
      take      = (state == S_IDLE) || stop_end;
      load_pend = take && pend_v;
      load      = load_pend || (take && send_tick);
      drop      = send_tick && pend_v;
      store     = send_tick && !pend_v && !take;
      load_byte = pend_v ? pend_b : din;
   end

   always_ff @(posedge clk_50Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (load) state_nx = S_START;
         end
         S_START: begin
            if (bit_tick) state_nx = S_DATA;
         end
         S_DATA: begin
            if (bit_tick && idx == 3'd7) begin
               state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (bit_tick) state_nx = S_STOP;
         end
         S_STOP: begin
            if (bit_tick) state_nx = load ? S_START : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      line_bit = 1'b1;
      unique case (state)
         S_START:  line_bit = 1'b0;
         S_DATA:   line_bit = sh[0];
         S_PARITY: line_bit = par;
         default:  line_bit = 1'b1;
      endcase
   end

   always_ff @(posedge clk_50Mhz or negedge rst_n) begin
      if (!rst_n) begin
         tx           <= 1'b1;
         tx_busy      <= 1'b0;
         tx_done_tick <= 1'b0;
         overrun_tick <= 1'b0;
         sh           <= '0;
         par          <= 1'b0;
         idx          <= '0;
         pend_v       <= 1'b0;
         pend_b       <= '0;
      end else begin
         tx           <= line_bit;
         tx_busy      <= (state != S_IDLE) || pend_v;
         tx_done_tick <= stop_end;
         overrun_tick <= drop;
         if (load) begin
            sh  <= load_byte;
            par <= even_parity(load_byte);
            idx <= '0;
         end else if (state == S_DATA && bit_tick) begin
            sh  <= {1'b0, sh[7:1]};
            idx <= idx + 3'd1;
         end
         unique case (1'b1)
            load_pend: pend_v <= 1'b0;
            store: begin
               pend_v <= 1'b1;
               pend_b <= din;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_btn_uart_tx.sv
// Randomized bench for btn_uart_tx, with and without parity, against
// a frame-timeline reference model.
module tb_btn_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       send_tick = 1'b0;
   logic [7:0] din = 8'h00;
   logic [1:0] tx_w;
   logic [1:0] busy_w;
   logic [1:0] done_w;
   logic [1:0] ovr_w;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   btn_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (0)
   ) u0 (
      .clk_50Mhz   (clk),
      .rst_n       (rst_n),
      .send_tick   (send_tick),
      .din         (din),
      .tx          (tx_w[0]),
      .tx_busy     (busy_w[0]),
      .tx_done_tick(done_w[0]),
      .overrun_tick(ovr_w[0])
   );

   btn_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (1)
   ) u1 (
      .clk_50Mhz   (clk),
      .rst_n       (rst_n),
      .send_tick   (send_tick),
      .din         (din),
      .tx          (tx_w[1]),
      .tx_busy     (busy_w[1]),
      .tx_done_tick(done_w[1]),
      .overrun_tick(ovr_w[1])
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model: each frame is a start edge plus a list of line bits.
   int          m_act[2];
   int          m_s[2];
   logic [10:0] m_bits[2];
   logic        m_pv[2];
   logic [7:0]  m_pb[2];
   int          ovr_cnt[2];
   int          e;

   function automatic int flen(input int i);
      return (i == 0) ? 10 * CPB : 11 * CPB;
   endfunction

   function automatic logic [10:0] mkbits(input int i, input logic [7:0] d);
      if (i == 0) return {2'b11, d, 1'b0};
      return {1'b1, ^d, d, 1'b0};
   endfunction

   initial begin : monitor
      logic       tk;
      logic [7:0] dv;
      logic       etx[2];
      logic       edone[2];
      logic       ebusy[2];
      logic       eovr[2];
      int         len;
      e = 0;
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 0; m_pv[i] = 0; m_s[i] = 0;
         m_bits[i] = '0; m_pb[i] = '0; ovr_cnt[i] = 0;
      end
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
               m_act[i] = 0;
               m_pv[i] = 0;
            end
         end else begin
            tk = send_tick;
            dv = din;
            for (int i = 0; i < 2; i++) begin
               len = flen(i);
               if (m_act[i] != 0 && e >= m_s[i] + 1 && e <= m_s[i] + len)
                  etx[i] = m_bits[i][(e - m_s[i] - 1) / CPB];
               else
                  etx[i] = 1'b1;
               edone[i] = (m_act[i] != 0) && (e == m_s[i] + len);
               ebusy[i] = ((m_act[i] != 0) && (e - 1 >= m_s[i])
                          && (e - 1 < m_s[i] + len)) || m_pv[i];
               eovr[i] = 1'b0;
               if (edone[i]) begin
                  m_act[i] = 0;
                  if (m_pv[i]) begin
                     m_act[i] = 1; m_s[i] = e;
                     m_bits[i] = mkbits(i, m_pb[i]);
                     m_pv[i] = 0;
                     eovr[i] = tk;
                  end else if (tk) begin
                     m_act[i] = 1; m_s[i] = e;
                     m_bits[i] = mkbits(i, dv);
                  end
               end else if (m_act[i] != 0) begin
                  if (tk && m_pv[i]) eovr[i] = 1'b1;
                  else if (tk) begin
                     m_pv[i] = 1; m_pb[i] = dv;
                  end
               end else if (tk) begin
                  m_act[i] = 1; m_s[i] = e;
                  m_bits[i] = mkbits(i, dv);
               end
            end
            e++;
            #1;
            for (int i = 0; i < 2; i++) begin
               check($sformatf("tx%0d", i), tx_w[i], etx[i]);
               check($sformatf("done%0d", i), done_w[i], edone[i]);
               check($sformatf("busy%0d", i), busy_w[i], ebusy[i]);
               check($sformatf("ovr%0d", i), ovr_w[i], eovr[i]);
               ovr_cnt[i] += int'(ovr_w[i]);
            end
         end
      end
   end

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      send_tick = 1'b1;
      din = d;
      @(negedge clk);
      send_tick = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_w != 2'b00 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(n >= 500), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic measure(input logic [7:0] d);
      int   c[2];
      logic p;
      c[0] = 0;
      c[1] = 0;
      p = 1'b0;
      send(d);
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (n == 38) p = tx_w[1];
         for (int i = 0; i < 2; i++)
            if (done_w[i] && c[i] == 0) c[i] = n;
      end
      check("done_lat0", c[0], 10 * CPB);
      check("done_lat1", c[1], 11 * CPB);
      check("par_bit", 32'(p), 32'(^d));
   endtask

   initial begin : stim
      int o0;
      int o1;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx_w), 3);
      check("rst_busy", 32'(busy_w), 0);
      check("rst_done", 32'(done_w), 0);
      check("rst_ovr", 32'(ovr_w), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      measure(8'hA5);
      wait_idle();
      measure(8'h07);
      wait_idle();

      o0 = ovr_cnt[0]; o1 = ovr_cnt[1];
      send(8'h11);
      repeat (8) @(negedge clk);
      send(8'h22);
      wait_idle();
      check("b2b_ovr0", ovr_cnt[0] - o0, 0);
      check("b2b_ovr1", ovr_cnt[1] - o1, 0);

      o0 = ovr_cnt[0]; o1 = ovr_cnt[1];
      send(8'h11);
      repeat (5) @(negedge clk);
      send(8'h22);
      repeat (5) @(negedge clk);
      send(8'h33);
      wait_idle();
      check("drop_ovr0", ovr_cnt[0] - o0, 1);
      check("drop_ovr1", ovr_cnt[1] - o1, 1);

      send(8'h44);
      repeat (10 * CPB - 2) @(negedge clk);
      send(8'h55);
      check("stop_hold", 32'(tx_w[0]), 1);
      @(posedge clk);
      #1;
      check("stop_next", 32'(tx_w[0]), 0);
      wait_idle();

      send(8'hA5);
      repeat (17) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_tx", 32'(tx_w), 3);
      check("abort_busy", 32'(busy_w), 0);
      check("abort_done", 32'(done_w), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      measure(8'h3C);
      wait_idle();

      repeat (4000) begin
         @(negedge clk);
         send_tick = ($urandom_range(0, 19) == 0);
         din = 8'($urandom);
      end
      @(negedge clk);
      send_tick = 1'b0;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
